// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and
// drives datapath mux selects, enables and ALU control from the current state.
//
//  state    | meaning
//  ---------+------------------------------------------------------
//  FETCH    | read instruction at PC, PC <= PC+4
//  DECODE   | read regs, compute branch target, dispatch on opcode
//  MEMADR   | rs1 + imm for lw/sw
//  MEMREAD  | read data memory at ALUOut
//  MEMWB    | write loaded data to rd
//  MEMWRITE | write rs2 to data memory at ALUOut
//  EXECR    | R-type ALU op on rs1, rs2
//  EXECI    | I-type ALU op on rs1, imm
//  ALUWB    | write ALUOut to rd
//  BRANCH   | compare rs1/rs2, take branch on zero ^ funct3[0]
//  JAL      | rd link value = oldPC + 4, PC <= target
module mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       pcwrite_o,
  output logic       adrsrc_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regwrite_o,
  output logic [1:0] resultsrc_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] immsrc_o,
  output logic [2:0] alucontrol_o,
  output logic       illegal_o,
  output logic       retire_o
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [STATE_W-1:0] state_q, state_d;
  logic               legal;
  logic               pcupdate, branch;
  logic [1:0]         aluop;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    legal = 1'b0;
    case (op_i)
      OP_LW, OP_SW: legal = (funct3_i == 3'b010);
      OP_R, OP_I:   legal = (funct3_i inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111});
      OP_BR:        legal = (funct3_i inside {3'b000, 3'b001});
      OP_JAL:       legal = 1'b1;
      default:      legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (legal) begin
          case (op_i)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_BR:        state_d = S_BRANCH;
            default:      state_d = S_JAL;
          endcase
        end
      end
      S_MEMADR:          state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:         state_d = S_MEMWB;
      S_EXECR, S_EXECI:  state_d = S_ALUWB;
      S_JAL:             state_d = S_ALUWB;
      default:           state_d = S_FETCH;
    endcase
  end

  always_comb begin
    adrsrc_o    = 1'b0;
    memwrite_o  = 1'b0;
    irwrite_o   = 1'b0;
    regwrite_o  = 1'b0;
    resultsrc_o = 2'b00;
    alusrca_o   = 2'b00;
    alusrcb_o   = 2'b00;
    aluop       = ALUOP_ADD;
    illegal_o   = 1'b0;
    retire_o    = 1'b0;
    pcupdate    = 1'b0;
    branch      = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_o   = 1'b1;
        alusrcb_o   = 2'b10;
        resultsrc_o = 2'b10;
        pcupdate    = 1'b1;
      end
      S_DECODE: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b01;
        illegal_o = ~legal;
      end
      S_MEMADR: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
      end
      S_MEMREAD: adrsrc_o = 1'b1;
      S_MEMWB: begin
        resultsrc_o = 2'b01;
        regwrite_o  = 1'b1;
        retire_o    = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_o   = 1'b1;
        memwrite_o = 1'b1;
        retire_o   = 1'b1;
      end
      S_EXECR: begin
        alusrca_o = 2'b10;
        aluop     = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite_o = 1'b1;
        retire_o   = 1'b1;
      end
      S_BRANCH: begin
        alusrca_o = 2'b10;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
        retire_o  = 1'b1;
      end
      S_JAL: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
        pcupdate  = 1'b1;
      end
      default: ;
    endcase
  end

  // bne shares the beq compare; funct3[0] flips the sense of zero
  assign pcwrite_o = pcupdate | (branch & (zero_i ^ funct3_i[0]));

  always_comb begin
    case (op_i)
      OP_SW:   immsrc_o = 2'b01;
      OP_BR:   immsrc_o = 2'b10;
      OP_JAL:  immsrc_o = 2'b11;
      default: immsrc_o = 2'b00;
    endcase
  end

  always_comb begin
    alucontrol_o = 3'b000;
    case (aluop)
      ALUOP_SUB: alucontrol_o = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (funct7b5_i & op_i[5]) ? 3'b001 : 3'b000;
          3'b010:  alucontrol_o = 3'b101;
          3'b100:  alucontrol_o = 3'b100;
          3'b110:  alucontrol_o = 3'b011;
          3'b111:  alucontrol_o = 3'b010;
          default: alucontrol_o = 3'b000;
        endcase
      end
      default: alucontrol_o = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed and random instructions
// compared cycle by cycle against a per-instruction-class output model.
module tb_mc_controller;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [6:0] op_i = 7'd0;
  logic [2:0] funct3_i = 3'd0;
  logic       funct7b5_i = 1'b0;
  logic       zero_i = 1'b0;
  logic       pcwrite_o, adrsrc_o, memwrite_o, irwrite_o, regwrite_o;
  logic [1:0] resultsrc_o, alusrca_o, alusrcb_o, immsrc_o;
  logic [2:0] alucontrol_o;
  logic       illegal_o, retire_o;

  int errors = 0;
  int checks = 0;

  mc_controller #(.STATE_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .op_i(op_i), .funct3_i(funct3_i),
    .funct7b5_i(funct7b5_i), .zero_i(zero_i), .pcwrite_o(pcwrite_o),
    .adrsrc_o(adrsrc_o), .memwrite_o(memwrite_o), .irwrite_o(irwrite_o),
    .regwrite_o(regwrite_o), .resultsrc_o(resultsrc_o), .alusrca_o(alusrca_o),
    .alusrcb_o(alusrcb_o), .immsrc_o(immsrc_o), .alucontrol_o(alucontrol_o),
    .illegal_o(illegal_o), .retire_o(retire_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic       illegal, retire;
  } outs_t;

  localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3, C_I = 4, C_BR = 5, C_JAL = 6;

  function automatic outs_t sample();
    outs_t o;
    o.pcwrite = pcwrite_o;   o.adrsrc = adrsrc_o;     o.memwrite = memwrite_o;
    o.irwrite = irwrite_o;   o.regwrite = regwrite_o; o.resultsrc = resultsrc_o;
    o.alusrca = alusrca_o;   o.alusrcb = alusrcb_o;   o.immsrc = immsrc_o;
    o.alucontrol = alucontrol_o; o.illegal = illegal_o; o.retire = retire_o;
    return o;
  endfunction

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return (f3 == 3'b010) ? C_LW : C_ILL;
      7'b0100011: return (f3 == 3'b010) ? C_SW : C_ILL;
      7'b0110011: return (f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111}) ? C_R : C_ILL;
      7'b0010011: return (f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111}) ? C_I : C_ILL;
      7'b1100011: return (f3 <= 3'b001) ? C_BR : C_ILL;
      7'b1101111: return C_JAL;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic int n_cycles(input int cls);
    case (cls)
      C_LW:    return 5;
      C_SW, C_R, C_I, C_JAL: return 4;
      C_BR:    return 3;
      default: return 2;
    endcase
  endfunction

  // add/sub/slt/xor/or/and as named by funct3; sub only for R-type with instr[30]
  function automatic logic [2:0] alu_op_of(input int cls, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'b000:  return (cls == C_R && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic outs_t expect_out(input int cls, input int cyc, input logic [6:0] op,
                                       input logic [2:0] f3, input logic f7b5, input logic z);
    outs_t e = '0;
    e.immsrc = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
               (op == 7'b1101111) ? 2'b11 : 2'b00;
    if (cyc == 0) begin
      e.irwrite = 1; e.pcwrite = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10;
    end else if (cyc == 1) begin
      e.alusrca = 2'b01; e.alusrcb = 2'b01; e.illegal = (cls == C_ILL);
    end else begin
      case (cls)
        C_LW, C_SW: begin
          if (cyc == 2) begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
          else if (cls == C_SW) begin e.adrsrc = 1; e.memwrite = 1; e.retire = 1; end
          else if (cyc == 3) e.adrsrc = 1;
          else begin e.resultsrc = 2'b01; e.regwrite = 1; e.retire = 1; end
        end
        C_R, C_I: begin
          if (cyc == 2) begin
            e.alusrca = 2'b10; e.alusrcb = (cls == C_I) ? 2'b01 : 2'b00;
            e.alucontrol = alu_op_of(cls, f3, f7b5);
          end else begin e.regwrite = 1; e.retire = 1; end
        end
        C_BR: begin
          e.alusrca = 2'b10; e.alucontrol = 3'b001; e.retire = 1;
          e.pcwrite = z ^ f3[0];
        end
        C_JAL: begin
          if (cyc == 2) begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1; end
          else begin e.regwrite = 1; e.retire = 1; end
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Entry: just after a rising edge with the DUT in FETCH. Exit: same condition.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                           input logic z, input string name);
    int cls = classify(op, f3);
    int n = n_cycles(cls);
    int retires = 0;
    outs_t o, e;
    op_i = op; funct3_i = f3; funct7b5_i = f7b5; zero_i = z;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      o = sample();
      e = expect_out(cls, c, op, f3, f7b5, z);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cyc%0d op=%b f3=%b f7b5=%b z=%b: got %b expected %b",
                 name, c, op, f3, f7b5, z, o, e);
      end
      retires += int'(o.retire);
      @(posedge clk_i); #1;
    end
    checks++;
    if (retires !== ((cls == C_ILL) ? 0 : 1)) begin
      errors++;
      $display("FAIL %s retire_count: got %0d expected %0d", name, retires, (cls == C_ILL) ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    outs_t o, e;
    repeat (3) @(posedge clk_i);
    #1;
    o = sample();
    e = expect_out(C_ILL, 0, 7'd0, 3'd0, 1'b0, 1'b0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_fetch: got %b expected %b", o, e);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_reset_mid_instr();
    outs_t o, e;
    op_i = 7'b0110011; funct3_i = 3'b000; funct7b5_i = 1'b0; zero_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    o = sample();
    checks++;
    if (o.alusrca !== 2'b10 || o.regwrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_execr_pre: got alusrca=%b regwrite=%b expected 10/0", o.alusrca, o.regwrite);
    end
    reset_i = 1'b1;
    #1;
    e = expect_out(C_R, 0, op_i, funct3_i, funct7b5_i, zero_i);
    o = sample();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", o, e);
    end
    repeat (2) @(posedge clk_i);
    #1;
    o = sample();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", o, e);
    end
    reset_i = 1'b0;
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, "add_after_reset");
  endtask

  task automatic test_directed();
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, "add");
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, "sub");
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, "addi_f7b5");
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, "and");
    run_instr(7'b0010011, 3'b010, 1'b0, 1'b1, "slti");
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, "beq_taken");
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, "beq_not");
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, "bne_not");
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, "bne_taken");
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, "lw");
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, "sw");
    run_instr(7'b1101111, 3'b101, 1'b1, 1'b0, "jal");
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, "illegal_op");
    run_instr(7'b0110011, 3'b001, 1'b0, 1'b0, "illegal_r_f3");
    run_instr(7'b0000011, 3'b000, 1'b0, 1'b0, "illegal_lw_f3");
    run_instr(7'b1100011, 3'b100, 1'b0, 1'b1, "illegal_br_f3");
  endtask

  task automatic test_back_to_back_random();
    logic [6:0] op;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 7))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        default: op = 7'($urandom);
      endcase
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_instr();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
